rf_writeback_queue: RTL and testbench

//  Writeback stage directly upstream of the register file write port (busW/RD/wen).

---
 rtl/rf_writeback_queue_if.sv | 42 ++++
 rtl/rf_writeback_queue.sv | 137 +++++++++++++
 tb/tb_rf_writeback_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_queue_if.sv
// Handshake and data bundle for the register-file writeback queue.
// master: EXU/LSU producers, the read-operand path and the register file.
// slave : the writeback queue itself.
interface rf_wb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  exu_valid;
  logic                  exu_ready;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [DATA_WIDTH-1:0] rf_busA;
  logic [DATA_WIDTH-1:0] rf_busB;
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opB;
  logic                  hazard;
  logic [CW-1:0]         count;

  modport master (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    output rs1, rs2, rf_busA, rf_busB,
    input  exu_ready, lsu_ready, rf_wen, rf_rd, rf_wdata, opA, opB, hazard, count
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    input  rs1, rs2, rf_busA, rf_busB,
    output exu_ready, lsu_ready, rf_wen, rf_rd, rf_wdata, opA, opB, hazard, count
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// Writeback queue in front of the register-file write port.
// LSU has fixed priority over EXU; accepted writes to x0 are dropped.
// The head entry is written to the register file every cycle the queue is non-empty.
// Optional feature macro: RF_WB_FWD_EN -- forward the youngest matching queued write
// onto opA/opB instead of raising hazard.
module rf_writeback_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input logic   clk,
  input logic   rst,
  rf_wb_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] last_rd_q;
  logic [DATA_WIDTH-1:0] last_data_q;

  logic                  not_full_s;
  logic                  lsu_ready_s;
  logic                  exu_ready_s;
  logic                  pop_s;
  logic                  push_s;
  logic [ADDR_WIDTH-1:0] in_rd_s;
  logic [DATA_WIDTH-1:0] in_data_s;
  logic [PW-1:0]         idx_s;
  logic [DATA_WIDTH-1:0] op_a_s;
  logic [DATA_WIDTH-1:0] op_b_s;
  logic                  hazard_s;

  // Ready, arbitration and next-state pointer/count computation
  always_comb begin
    not_full_s  = (count_q != CW'(DEPTH));
    lsu_ready_s = not_full_s & ~rst;
    exu_ready_s = not_full_s & ~wb.lsu_valid & ~rst;
    pop_s       = (count_q != {CW{1'b0}});
    push_s      = 1'b0;
    in_rd_s     = {ADDR_WIDTH{1'b0}};
    in_data_s   = {DATA_WIDTH{1'b0}};
    if (wb.lsu_valid && lsu_ready_s) begin
      push_s    = (wb.lsu_rd != {ADDR_WIDTH{1'b0}});
      in_rd_s   = wb.lsu_rd;
      in_data_s = wb.lsu_data;
    end else if (wb.exu_valid && exu_ready_s) begin
      push_s    = (wb.exu_rd != {ADDR_WIDTH{1'b0}});
      in_rd_s   = wb.exu_rd;
      in_data_s = wb.exu_data;
    end else begin
      push_s    = 1'b0;
    end
    head_d = pop_s  ? head_q + PW'(1) : head_q;
    tail_d = push_s ? tail_q + PW'(1) : tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and last-retired-write registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      last_rd_q   <= {ADDR_WIDTH{1'b0}};
      last_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop_s) begin
        last_rd_q   <= rd_q[head_q];
        last_data_q <= data_q[head_q];
      end else begin
        last_rd_q   <= last_rd_q;
        last_data_q <= last_data_q;
      end
    end
  end

  // Entry storage; only the valid window between head and tail is ever consumed
  always_ff @(posedge clk) begin
    if (push_s) begin
      rd_q[tail_q]   <= in_rd_s;
      data_q[tail_q] <= in_data_s;
    end
  end

`ifdef RF_WB_FWD_EN
  // Scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    op_a_s   = wb.rf_busA;
    op_b_s   = wb.rf_busB;
    hazard_s = 1'b0;
    idx_s    = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s  = head_q + PW'(k);
      op_a_s = ((k < int'(count_q)) && (rd_q[idx_s] == wb.rs1) &&
                (wb.rs1 != {ADDR_WIDTH{1'b0}})) ? data_q[idx_s] : op_a_s;
      op_b_s = ((k < int'(count_q)) && (rd_q[idx_s] == wb.rs2) &&
                (wb.rs2 != {ADDR_WIDTH{1'b0}})) ? data_q[idx_s] : op_b_s;
    end
  end
`else
  // Stall the EXU while any queued write (head included) targets rs1 or rs2
  always_comb begin
    op_a_s   = wb.rf_busA;
    op_b_s   = wb.rf_busB;
    hazard_s = 1'b0;
    idx_s    = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s    = head_q + PW'(k);
      hazard_s = hazard_s | ((k < int'(count_q)) &&
                 (((rd_q[idx_s] == wb.rs1) && (wb.rs1 != {ADDR_WIDTH{1'b0}})) ||
                  ((rd_q[idx_s] == wb.rs2) && (wb.rs2 != {ADDR_WIDTH{1'b0}}))));
    end
  end
`endif

  assign wb.exu_ready = exu_ready_s;
  assign wb.lsu_ready = lsu_ready_s;
  assign wb.rf_wen    = pop_s;
  assign wb.rf_rd     = pop_s ? rd_q[head_q]   : last_rd_q;
  assign wb.rf_wdata  = pop_s ? data_q[head_q] : last_data_q;
  assign wb.opA       = op_a_s;
  assign wb.opB       = op_b_s;
  assign wb.hazard    = hazard_s;
  assign wb.count     = count_q;
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Randomized self-checking bench for rf_writeback_queue against a queue-based
// reference model; the bench also plays the register file, updated from the model.
module tb_rf_writeback_queue;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) wb();

  rf_writeback_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] mrf [32];
  logic [AW-1:0] m_last_rd;
  logic [DW-1:0] m_last_data;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit r, input bit ev, input logic [AW-1:0] erd, input logic [DW-1:0] ed,
                      input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                      input logic [AW-1:0] a, input logic [AW-1:0] b);
    bit            nf, exp_lr, exp_er, exp_haz;
    logic [DW-1:0] exp_a, exp_b;
    @(negedge clk);
    rst          = r;
    wb.exu_valid = ev;  wb.exu_rd = erd; wb.exu_data = ed;
    wb.lsu_valid = lv;  wb.lsu_rd = lrd; wb.lsu_data = ld;
    wb.rs1       = a;   wb.rs2    = b;
    wb.rf_busA   = mrf[a];
    wb.rf_busB   = mrf[b];
    #1;
    nf      = (mq.size() != DEPTH);
    exp_lr  = nf && !r;
    exp_er  = nf && !lv && !r;
    exp_a   = mrf[a];
    exp_b   = mrf[b];
    exp_haz = 1'b0;
    foreach (mq[i]) begin
`ifdef RF_WB_FWD_EN
      if (a != 0 && mq[i].rd == a) exp_a = mq[i].data;
      if (b != 0 && mq[i].rd == b) exp_b = mq[i].data;
`else
      if ((a != 0 && mq[i].rd == a) || (b != 0 && mq[i].rd == b)) exp_haz = 1'b1;
`endif
    end
    check_val("lsu_ready", 64'(wb.lsu_ready), 64'(exp_lr));
    check_val("exu_ready", 64'(wb.exu_ready), 64'(exp_er));
    check_val("count",     64'(wb.count),     64'(mq.size()));
    check_val("rf_wen",    64'(wb.rf_wen),    64'(mq.size() != 0));
    check_val("rf_rd",     64'(wb.rf_rd),     64'((mq.size() != 0) ? mq[0].rd   : m_last_rd));
    check_val("rf_wdata",  64'(wb.rf_wdata),  64'((mq.size() != 0) ? mq[0].data : m_last_data));
    check_val("hazard",    64'(wb.hazard),    64'(exp_haz));
    check_val("opA",       64'(wb.opA),       64'(exp_a));
    check_val("opB",       64'(wb.opB),       64'(exp_b));
    if (r) begin
      mq.delete();
      m_last_rd   = '0;
      m_last_data = '0;
    end else begin
      if (mq.size() != 0) begin
        mrf[mq[0].rd] = mq[0].data;
        m_last_rd     = mq[0].rd;
        m_last_data   = mq[0].data;
        void'(mq.pop_front());
      end
      if (lv && exp_lr) begin
        if (lrd != 0) mq.push_back('{lrd, ld});
      end else if (ev && exp_er) begin
        if (erd != 0) mq.push_back('{erd, ed});
      end
    end
  endtask

  task automatic idle(input logic [AW-1:0] a, input logic [AW-1:0] b);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a, b);
  endtask

  initial begin
    foreach (mrf[i]) mrf[i] = '0;
    m_last_rd = '0; m_last_data = '0;
    rst = 1'b1;
    wb.exu_valid = 1'b0; wb.exu_rd = '0; wb.exu_data = '0;
    wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
    wb.rs1 = '0; wb.rs2 = '0; wb.rf_busA = '0; wb.rf_busB = '0;
    repeat (2) @(posedge clk);

    // Reset cycle: readies held low even with requests pending
    step(1'b1, 1'b1, 5'd2, 32'h1, 1'b1, 5'd3, 32'h2, 5'd0, 5'd0);
    check_val("rst_lsu_ready", 64'(wb.lsu_ready), 64'd0);
    check_val("rst_count", 64'(wb.count), 64'd0);

    // Single EXU write to x5
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    check_val("single_wen", 64'(wb.rf_wen), 64'd1);
    check_val("single_rd",  64'(wb.rf_rd),  64'd5);
    idle(5'd5, 5'd0);
    check_val("single_busA", 64'(wb.opA), 64'hDEADBEEF);
    check_val("single_cnt",  64'(wb.count), 64'd0);

    // LSU write to x0 is accepted and dropped
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
    check_val("x0_lsu_ready", 64'(wb.lsu_ready), 64'd1);
    idle(5'd0, 5'd0);
    check_val("x0_wen", 64'(wb.rf_wen), 64'd0);

    // Arbitration: LSU x3 wins, EXU x4 follows
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
    check_val("arb_exu_ready", 64'(wb.exu_ready), 64'd0);
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, '0, '0, 5'd3, 5'd4);
    check_val("arb_first_rd", 64'(wb.rf_rd), 64'd3);
    idle(5'd3, 5'd4);
    check_val("arb_second_rd", 64'(wb.rf_rd), 64'd4);
    idle(5'd3, 5'd4);

    // Two writes to x7 in a row, then read x7
    step(1'b0, 1'b1, 5'd7, 32'd1, 1'b0, '0, '0, 5'd7, 5'd0);
    step(1'b0, 1'b1, 5'd7, 32'd2, 1'b0, '0, '0, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
`ifdef RF_WB_FWD_EN
    check_val("fwd_opA", 64'(wb.opA), 64'd2);
`else
    check_val("haz_pending", 64'(wb.hazard), 64'd1);
`endif
    idle(5'd7, 5'd0);
    check_val("fwd_final_opA", 64'(wb.opA), 64'd2);

    // Reset mid-operation discards the queued write to x7
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 5'd7, 5'd0);
    step(1'b1, 1'b1, 5'd7, 32'h78, 1'b0, '0, '0, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    check_val("rstmid_wen", 64'(wb.rf_wen), 64'd0);
    check_val("rstmid_busA", 64'(wb.opA), 64'd2);

    // Ten back-to-back EXU writes, pointers wrap
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b1, AW'(i), 32'h100 + 32'(i), 1'b0, '0, '0, AW'(i), 5'd0);
    repeat (3) idle(5'd10, 5'd1);
    check_val("wrap_last", 64'(wb.opA), 64'h10A);

    // Randomized traffic with a small register range to provoke matches
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) < 2),
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
